// File: rtl/extrema_cmp_sched_if.sv
// Request/response bundle for extrema_cmp_sched.
// The master drives the request and the 3x3x3 cube. The slave returns status and results.
interface extrema_cmp_sched_if;
  logic         iStart;
  logic [215:0] iCube;
  logic         oBusy;
  logic         oDone;
  logic         oIsMax;
  logic         oIsMin;

  modport master (
    output iStart,
    output iCube,
    input  oBusy,
    input  oDone,
    input  oIsMax,
    input  oIsMin
  );

  modport slave (
    input  iStart,
    input  iCube,
    output oBusy,
    output oDone,
    output oIsMax,
    output oIsMin
  );
endinterface

// File: rtl/extrema_cmp_sched.sv
// Time-multiplexed SIFT extremum test. One registered 1-vs-3 ">=" comparator is swept
// over the 26 neighbours twice: a max pass, then a min pass that uses inverted operands.
// Optional build macro: EXTREMA_EARLY_EXIT_EN. When it is defined, the scheduler skips
// the rest of a pass as soon as that pass has a failing result.
module extrema_cmp_sched (
  input  logic                      iclk,
  input  logic                      irst_n,
  extrema_cmp_sched_if.slave        bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [4:0] LastStep = 5'd17;
  localparam logic [4:0] MinStep  = 5'd9;

  state_e       state_q;
  logic [4:0]   step_q;
  logic [215:0] cube_q;
  logic         acc_max_q, acc_min_q;
  logic         cmp_vld_q, cmp_res_q, cmp_tag_q;  // tag: 0 = max pass, 1 = min pass
  logic         busy_q, done_q, is_max_q, is_min_q;

  logic [7:0]   nb [27];
  logic [7:0]   centre;
  logic         min_pass;
  logic [4:0]   grp, base;
  logic [7:0]   op_a, op_b0, op_b1, op_b2;
  logic         cmp_res;
  logic         ret_fail_max, ret_fail_min;
  logic         acc_max_nxt, acc_min_nxt;

  // Neighbour list skips the centre (byte 13). Slot 26 duplicates n25 to fill group 8.
  always_comb begin
    for (int k = 0; k < 13; k++) nb[k] = cube_q[8*k +: 8];
    for (int k = 13; k < 26; k++) nb[k] = cube_q[8*(k+1) +: 8];
    nb[26] = cube_q[8*26 +: 8];
  end

  // Select the operands for the current step. The min pass inverts every operand.
  always_comb begin
    centre   = cube_q[104 +: 8];
    min_pass = (step_q >= MinStep);
    grp      = min_pass ? (step_q - MinStep) : step_q;
    base     = grp * 5'd3;
    op_a     = min_pass ? ~centre : centre;
    op_b0    = min_pass ? ~nb[base]        : nb[base];
    op_b1    = min_pass ? ~nb[base + 5'd1] : nb[base + 5'd1];
    op_b2    = min_pass ? ~nb[base + 5'd2] : nb[base + 5'd2];
    cmp_res  = (op_a >= op_b0) && (op_a >= op_b1) && (op_a >= op_b2);
  end

  // Fold the result that retires this cycle into its accumulator.
  always_comb begin
    ret_fail_max = cmp_vld_q && !cmp_tag_q && !cmp_res_q;
    ret_fail_min = cmp_vld_q &&  cmp_tag_q && !cmp_res_q;
    acc_max_nxt  = acc_max_q & ~ret_fail_max;
    acc_min_nxt  = acc_min_q & ~ret_fail_min;
  end

  // Scheduler FSM, comparator pipe, accumulators and registered outputs.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q   <= StIdle;
      step_q    <= '0;
      cube_q    <= '0;
      acc_max_q <= 1'b1;
      acc_min_q <= 1'b1;
      cmp_vld_q <= 1'b0;
      cmp_res_q <= 1'b0;
      cmp_tag_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      is_max_q  <= 1'b0;
      is_min_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cmp_vld_q <= 1'b0;
      acc_max_q <= acc_max_nxt;
      acc_min_q <= acc_min_nxt;
      unique case (state_q)
        StIdle: begin
          if (bus.iStart) begin
            cube_q    <= bus.iCube;
            step_q    <= '0;
            acc_max_q <= 1'b1;
            acc_min_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StRun;
          end
        end
        StRun: begin
          cmp_vld_q <= 1'b1;
          cmp_res_q <= cmp_res;
          cmp_tag_q <= min_pass;
          step_q    <= step_q + 5'd1;
          if (step_q == LastStep) state_q <= StDrain;
`ifdef EXTREMA_EARLY_EXIT_EN
          // A failing max result ends the max pass. A failing min result ends the scan.
          // The compare issued in this cycle is dropped in both cases.
          if (ret_fail_max && !min_pass) begin
            cmp_vld_q <= 1'b0;
            step_q    <= MinStep;
          end else if (ret_fail_min) begin
            cmp_vld_q <= 1'b0;
            state_q   <= StDrain;
          end
`endif
        end
        StDrain: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          is_max_q <= acc_max_nxt;
          is_min_q <= acc_min_nxt;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.oBusy  = busy_q;
  assign bus.oDone  = done_q;
  assign bus.oIsMax = is_max_q;
  assign bus.oIsMin = is_min_q;

endmodule
